// File: rtl/execute_stage_md_pkg.sv
// Shared encodings for the execute stage: ALU ops, forward selects, HI/LO reads,
// multiply/divide opcodes and the multiply/divide sequencer states.
package execute_stage_md_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    localparam logic [1:0] FWD_RD   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_ZERO = 2'b11;

    localparam logic [1:0] HL_ALU = 2'b00;
    localparam logic [1:0] HL_LO  = 2'b01;
    localparam logic [1:0] HL_HI  = 2'b10;

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_e;

    // Odd opcodes (MULT, DIV) are the signed variants; the upper bit selects divide.
    function automatic logic md_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/execute_stage_md_mul_div_unit.sv
// Iterative multiply/divide: one shift-add or restoring shift-subtract step per cycle
// on operand magnitudes, with sign correction and the HI/LO write in a final cycle.
module mul_div_unit
    import execute_stage_md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(DATA_W + 1);

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [DATA_W-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0]   mag_a, mag_b, addend;
    logic [DATA_W:0]     sum, shifted, diff;
    logic [2*DATA_W-1:0] prod;
    logic                neg_res;

    assign mag_a   = (md_is_signed(op) && a[DATA_W-1]) ? -a : a;
    assign mag_b   = (md_is_signed(op) && b[DATA_W-1]) ? -b : b;
    assign addend  = q_q[0] ? m_q : '0;
    assign sum     = {1'b0, acc_q} + {1'b0, addend};
    assign shifted = {acc_q, q_q[DATA_W-1]};
    assign diff    = shifted - {1'b0, m_q};
    assign prod    = {acc_q, q_q};
    assign neg_res = neg_a_q ^ neg_b_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            MD_IDLE: if (start) begin
                op_d    = op;
                neg_a_d = md_is_signed(op) & a[DATA_W-1];
                neg_b_d = md_is_signed(op) & b[DATA_W-1];
                acc_d   = '0;
                cnt_d   = CW'(DATA_W);
                // q holds the bits consumed each step: multiplier or dividend.
                q_d     = md_is_div(op) ? mag_a : mag_b;
                m_d     = md_is_div(op) ? mag_b : mag_a;
                state_d = MD_RUN;
            end
            MD_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (!md_is_div(op_q)) begin
                    acc_d = sum[DATA_W:1];
                    q_d   = {sum[0], q_q[DATA_W-1:1]};
                end else if (!diff[DATA_W]) begin
                    acc_d = diff[DATA_W-1:0];
                    q_d   = {q_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = shifted[DATA_W-1:0];
                    q_d   = {q_q[DATA_W-2:0], 1'b0};
                end
                if (cnt_q == CW'(1)) state_d = MD_FIX;
            end
            MD_FIX: begin
                if (md_is_div(op_q)) begin
                    // A zero divisor leaves the dividend magnitude in acc, so the
                    // ordinary remainder path already returns the raw dividend.
                    lo_d = (m_q == '0) ? '1 : (neg_res ? -q_q : q_q);
                    hi_d = neg_a_q ? -acc_q : acc_q;
                end else begin
                    {hi_d, lo_d} = neg_res ? -prod : prod;
                end
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != MD_IDLE);
    assign done = done_q;

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage: forwarding, ALUSrc and RegDst muxes, single-cycle ALU, and an
// iterative multiply/divide unit whose HI/LO are readable through ALUOUTE.
module execute_stage_md
    import execute_stage_md_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] RdE,
    input  logic [DATA_W-1:0] SignImmE,
    input  logic [DATA_W-1:0] aluOutM,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic              RegDstE,
    input  logic              ALUSrcE,
    input  logic [2:0]        ALUControlE,
    input  logic              MDStartE,
    input  logic [1:0]        MDOpE,
    input  logic [1:0]        HiLoReadE,
    output logic [DATA_W-1:0] ALUOUTE,
    output logic [DATA_W-1:0] WriteDataE,
    output logic [REG_AW-1:0] WriteRegE,
    output logic              ZeroE,
    output logic              MDBusyE,
    output logic              MDStallE,
    output logic              MDDoneE
);
    logic [DATA_W-1:0] src_a, src_b, alu_res, hi, lo;
    logic              md_busy, hl_read;

    always_comb begin
        case (ForwardAE)
            FWD_RD:  src_a = RD1E;
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = aluOutM;
            default: src_a = '0;
        endcase
        case (ForwardBE)
            FWD_RD:  WriteDataE = RD2E;
            FWD_WB:  WriteDataE = ResultW;
            FWD_MEM: WriteDataE = aluOutM;
            default: WriteDataE = '0;
        endcase
    end

    assign src_b = ALUSrcE ? SignImmE : WriteDataE;

    always_comb begin
        case (ALUControlE)
            ALU_AND: alu_res = src_a & src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_ADD: alu_res = src_a + src_b;
            ALU_SUB: alu_res = src_a - src_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (HiLoReadE)
            HL_LO:   ALUOUTE = lo;
            HL_HI:   ALUOUTE = hi;
            default: ALUOUTE = alu_res;
        endcase
    end

    assign ZeroE     = (alu_res == '0);
    assign WriteRegE = RegDstE ? RdE : RtE;
    assign hl_read   = (HiLoReadE == HL_LO) || (HiLoReadE == HL_HI);
    assign MDBusyE   = md_busy;
    // HI/LO reads stall too: ALUOUTE would otherwise return the pre-operation value.
    assign MDStallE  = md_busy & (MDStartE | hl_read);

    mul_div_unit #(.DATA_W(DATA_W)) u_md (
        .clk   (CLK),
        .rst_n (RST),
        .start (MDStartE),
        .op    (MDOpE),
        .a     (src_a),
        .b     (WriteDataE),
        .hi    (hi),
        .lo    (lo),
        .busy  (md_busy),
        .done  (MDDoneE)
    );

endmodule

// File: tb/tb_execute_stage_md.sv
// Scoreboard bench: the driver predicts every cycle's outputs from a behavioural
// model; a negedge monitor pops each prediction and compares it with the DUT.
module tb_execute_stage_md;
    localparam int W  = 32;
    localparam int RA = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [W-1:0]  RD1E, RD2E, SignImmE, aluOutM, ResultW;
    logic [RA-1:0] RtE, RdE;
    logic [1:0]    ForwardAE, ForwardBE, MDOpE, HiLoReadE;
    logic          RegDstE, ALUSrcE, MDStartE;
    logic [2:0]    ALUControlE;
    logic [W-1:0]  ALUOUTE, WriteDataE;
    logic [RA-1:0] WriteRegE;
    logic          ZeroE, MDBusyE, MDStallE, MDDoneE;

    execute_stage_md #(.DATA_W(W), .REG_AW(RA)) dut (
        .CLK(CLK), .RST(RST), .RD1E(RD1E), .RD2E(RD2E), .RtE(RtE), .RdE(RdE),
        .SignImmE(SignImmE), .aluOutM(aluOutM), .ResultW(ResultW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .RegDstE(RegDstE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MDStartE(MDStartE),
        .MDOpE(MDOpE), .HiLoReadE(HiLoReadE), .ALUOUTE(ALUOUTE),
        .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .ZeroE(ZeroE),
        .MDBusyE(MDBusyE), .MDStallE(MDStallE), .MDDoneE(MDDoneE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          rst_n;
        logic [W-1:0]  rd1, rd2, imm, aom, resw;
        logic [RA-1:0] rt, rd;
        logic [1:0]    fa, fb, op, hilo;
        logic          regdst, alusrc, start;
        logic [2:0]    ctl;
    } stim_t;

    typedef struct {
        logic [W-1:0]  out, wd;
        logic [RA-1:0] wreg;
        logic          zero, busy, stall, done;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: cycles of busy remaining, pending result, committed HI/LO.
    int           m_cnt;
    logic         m_done;
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt = 0; m_done = 1'b0; m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
    endfunction

    function automatic logic [W-1:0] fwd(input logic [1:0] sel, input stim_t s, input logic [W-1:0] rd);
        case (sel)
            2'd0: return rd;
            2'd1: return s.resw;
            2'd2: return s.aom;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] alu_ref(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a + b;
            3'b110: return a - b;
            3'b111: return (longint'($signed(a)) < longint'($signed(b))) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    function automatic void md_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [2*W-1:0] p;
        longint sa, sbv;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        hi = '0; lo = '0;
        case (op)
            2'd0: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; hi = p[2*W-1:W]; lo = p[W-1:0]; end
            2'd1: begin p = sa * sbv; hi = p[2*W-1:W]; lo = p[W-1:0]; end
            2'd2: if (b == 0) begin lo = '1; hi = a; end
                  else begin lo = a / b; hi = a % b; end
            default: if (b == 0) begin lo = '1; hi = a; end
                     else begin p = sa / sbv; lo = p[W-1:0]; p = sa % sbv; hi = p[W-1:0]; end
        endcase
    endfunction

    function automatic stim_t base();
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1'b1;
        s.ctl   = 3'b010;
        return s;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 9))
            0: v = '0;
            1: v = 32'h8000_0000;
            2: v = '1;
            3: v = 1;
            4: v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Apply one cycle of stimulus just after a rising edge, predict, then advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        logic [W-1:0] a, b, srcb, alu;
        RST = s.rst_n; RD1E = s.rd1; RD2E = s.rd2; SignImmE = s.imm; aluOutM = s.aom;
        ResultW = s.resw; RtE = s.rt; RdE = s.rd; ForwardAE = s.fa; ForwardBE = s.fb;
        RegDstE = s.regdst; ALUSrcE = s.alusrc; ALUControlE = s.ctl; MDStartE = s.start;
        MDOpE = s.op; HiLoReadE = s.hilo;
        if (!s.rst_n) model_reset();
        a    = fwd(s.fa, s, s.rd1);
        b    = fwd(s.fb, s, s.rd2);
        srcb = s.alusrc ? s.imm : b;
        alu  = alu_ref(s.ctl, a, srcb);
        e.out   = (s.hilo == 2'd1) ? m_lo : (s.hilo == 2'd2) ? m_hi : alu;
        e.wd    = b;
        e.wreg  = s.regdst ? s.rd : s.rt;
        e.zero  = (alu == 0);
        e.busy  = (m_cnt > 0);
        e.stall = e.busy && (s.start || s.hilo == 2'd1 || s.hilo == 2'd2);
        e.done  = m_done;
        exp_q.push_back(e);
        @(posedge CLK);
        if (!s.rst_n) model_reset();
        else if (m_cnt > 0) begin
            m_cnt--;
            m_done = (m_cnt == 0);
            if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else begin
            m_done = 1'b0;
            if (s.start) begin md_ref(s.op, a, b, p_hi, p_lo); m_cnt = W + 1; end
        end
        #1;
    endtask

    task automatic md_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        stim_t s;
        s = base(); s.start = 1'b1; s.op = op; s.rd1 = a; s.rd2 = b;
        step(s);
        repeat (W + 1) begin
            s = base(); s.hilo = 2'($urandom_range(0, 3));
            step(s);
        end
        s = base(); s.hilo = 2'd2; step(s);
        s.hilo = 2'd1; step(s);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("aluout",    ALUOUTE,    e.out);
            chk("writedata", WriteDataE, e.wd);
            chk("writereg",  W'(WriteRegE), W'(e.wreg));
            chk("zero",      W'(ZeroE),    W'(e.zero));
            chk("busy",      W'(MDBusyE),  W'(e.busy));
            chk("stall",     W'(MDStallE), W'(e.stall));
            chk("done",      W'(MDDoneE),  W'(e.done));
        end
    end

    initial begin
        stim_t s;
        model_reset();
        s = base(); s.rst_n = 1'b0;
        RST = 1'b0; RD1E = '0; RD2E = '0; SignImmE = '0; aluOutM = '0; ResultW = '0;
        RtE = '0; RdE = '0; ForwardAE = '0; ForwardBE = '0; RegDstE = 1'b0; ALUSrcE = 1'b0;
        ALUControlE = 3'b010; MDStartE = 1'b0; MDOpE = '0; HiLoReadE = '0;
        @(posedge CLK); #1;
        s.hilo = 2'd1; step(s);
        s.hilo = 2'd2; step(s);

        s = base(); s.fa = 2'd2; s.aom = 7; s.rd2 = 5; step(s);
        s = base(); s.rd1 = 5; s.rd2 = 5; s.ctl = 3'b110; step(s);
        s = base(); s.rd1 = '1; s.rd2 = 1; s.ctl = 3'b111; step(s);
        s = base(); s.fb = 2'd3; s.rd2 = 32'h1234; s.rt = 9; s.rd = 17; step(s);
        s.regdst = 1'b1; s.alusrc = 1'b1; s.imm = 32'hFFFF_FFFC; s.rd1 = 3; step(s);
        s = base(); s.ctl = 3'b011; s.rd1 = 6; s.rd2 = 6; step(s);

        md_op(2'd1, 32'hFFFF_FFFD, 7);
        md_op(2'd0, 32'hFFFF_FFFF, 2);
        md_op(2'd3, 32'hFFFF_FFF9, 2);
        md_op(2'd2, 7, 0);
        md_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        md_op(2'd3, 32'hFFFF_FFF9, 0);

        // Second start and a LO read while busy: ignored start, stall, old LO shown.
        s = base(); s.start = 1'b1; s.op = 2'd2; s.rd1 = 100; s.rd2 = 7; step(s);
        s = base(); s.start = 1'b1; s.op = 2'd0; s.rd1 = 9; s.rd2 = 9; s.hilo = 2'd1; step(s);
        repeat (W + 1) begin s = base(); s.hilo = 2'd1; step(s); end
        s = base(); s.hilo = 2'd2; step(s);

        // Reset in the middle of a divide.
        s = base(); s.start = 1'b1; s.op = 2'd2; s.rd1 = 1000; s.rd2 = 3; step(s);
        repeat (9) begin s = base(); step(s); end
        s = base(); s.rst_n = 1'b0; s.hilo = 2'd1; step(s);
        s.hilo = 2'd2; step(s);
        md_op(2'd0, 3, 4);

        for (int i = 0; i < 800; i++) begin
            s = base();
            s.rd1 = pick(); s.rd2 = pick(); s.imm = pick(); s.aom = pick(); s.resw = pick();
            s.rt = RA'($urandom_range(0, 31)); s.rd = RA'($urandom_range(0, 31));
            s.fa = 2'($urandom_range(0, 3)); s.fb = 2'($urandom_range(0, 3));
            s.regdst = 1'($urandom_range(0, 1)); s.alusrc = 1'($urandom_range(0, 1));
            s.ctl = 3'($urandom_range(0, 7)); s.start = ($urandom_range(0, 7) == 0);
            s.op = 2'($urandom_range(0, 3)); s.hilo = 2'($urandom_range(0, 3));
            step(s);
        end

        @(negedge CLK); #1;
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
